// File: rtl/serial_adder.sv
// Bit-serial adder: sum = a + b + c, one bit per cycle LSB-first. Optional SERIAL_ADDER_OVF_EN adds port ovf (signed overflow).
// Latency: WIDTH cycles in SHIFT; the result is valid in the first DONE cycle, WIDTH+1 edges counting the accepting edge.
// Backpressure: the result holds in DONE until out_ready; in_ready is high only in IDLE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cy_q, cy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              s_bit;
    logic              cy_nxt;
`ifdef SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        s_bit   = a_q[0] ^ b_q[0] ^ cy_q;
        cy_nxt  = (a_q[0] & b_q[0]) | (b_q[0] & cy_q) | (a_q[0] & cy_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cy_d    = c;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Shift-then-insert keeps this legal for WIDTH=1.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = s_bit;
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                cy_d             = cy_nxt;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // cy_q here is the carry into the MSB.
                    ovf_d   = cy_q ^ cy_nxt;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign sum       = sum_q;
    assign carry     = cy_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): the driver queues expected {ovf,carry,sum}, the monitor checks on each output handshake.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         busy;
    logic         dut_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc  = 0;
    int prev_acc = 0;
    logic [W+1:0] sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (dut_ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign dut_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {ovf, carry, sum}; ovf is only meaningful with the overflow port.
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        logic [W:0] s;
        logic       ov;
        s  = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        ov = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ov = (ta[W-1] == tb[W-1]) && (s[W-1] != ta[W-1]);
`endif
        return {ov, s};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%0h expected none", {dut_ovf, carry, sum});
            end else begin
                chk("result", {dut_ovf, carry, sum}, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit push);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        a = ta;
        b = tb;
        c = tc;
        in_valid = 1'b1;
        if (push) sb.push_back(model(ta, tb, tc));
        @(posedge clk);
        #1;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
    endtask

    task automatic wait_ov();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        total++;
        bad++;
        $display("FAIL out_valid_timeout: got 0 expected 1");
    endtask

    initial begin
        int edges;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_sum_carry", {carry, sum}, 0);
        rst_n = 1'b1;

        // First-result latency, counting the accepting edge as edge 1.
        send(8'h0F, 8'h01, 1'b0, 1'b1);
        edges = 1;
        @(negedge clk);
        chk("busy_in_shift", busy, 1);
        while (!out_valid && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency_edges", edges, 9);
        chk("sum_0f_01", {carry, sum}, 9'h010);

        // Back-to-back issue also measures the minimum issue interval.
        send(8'hFF, 8'h01, 1'b0, 1'b1);
        send(8'hFF, 8'hFF, 1'b1, 1'b1);
        chk("issue_interval", acc_cyc - prev_acc, W + 2);

        // Held result under backpressure; stray in_valid pulses must be ignored.
        wait_ov();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1, 1'b1);
        @(negedge clk);
        a = 8'hAA;
        b = 8'hAA;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            chk("hold_result",   {carry, sum}, 9'h047);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_vld",  out_valid, 1);
            in_valid = (i == 2);
            a = 8'h5A;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs",  {in_ready, out_valid, busy}, 3'b100);
        chk("retain_in_idle", {carry, sum}, 9'h047);

        // Reset in the middle of SHIFT discards the partial result.
        send(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {in_ready, out_valid, busy}, 3'b100);
        chk("midrst_sum",   {carry, sum}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h03, 8'h04, 1'b0, 1'b1);
        wait_ov();
        chk("sum_03_04", {carry, sum}, 9'h007);

`ifdef SERIAL_ADDER_OVF_EN
        send(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_ov();
        chk("ovf_7f_01", {dut_ovf, carry, sum}, 10'h280);
        send(8'h80, 8'h80, 1'b0, 1'b1);
        wait_ov();
        chk("ovf_80_80", {dut_ovf, carry, sum}, 10'h300);
`endif

        for (int t = 0; t < 1000; t++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        wait_ov();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
